// File: rtl/ycbcr_to_rgb565.sv
// ycbcr_to_rgb565
//   Converts 8-bit full-range BT.601 YCbCr back to RGB565 for the display
//   write path (inverse of the camera-side RGB565->YCbCr skin detector).
//   Fixed 4-stage pipeline, one pixel per clk, no backpressure.
//   Valid/hsync/vsync travel in shift registers alongside the data.
//
// Build option: define YCC2RGB_MASK_OVERLAY_EN to add mask_in. A masked
//   pixel is replaced by OVERLAY_COLOR at the output.
//
// Ports
//   clk        system clock, rising edge
//   Rst        asynchronous reset, active-low
//   in_valid   Y/Cb/Cr qualify this cycle
//   in_hsync   line sync, delayed 4 clk to out_hsync
//   in_vsync   frame sync, delayed 4 clk to out_vsync
//   in_y       luma, unsigned
//   in_cb      blue chroma, offset 128
//   in_cr      red chroma, offset 128
//   mask_in    face mask aligned with the pixel (overlay build only)
//   out_valid  out_rgb holds a new pixel
//   out_hsync  delayed line sync
//   out_vsync  delayed frame sync
//   out_rgb    {R[7:3],G[7:2],B[7:3]}, holds while out_valid=0
module ycbcr_to_rgb565 #(
  parameter logic [15:0] OVERLAY_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        in_valid,
  input  logic        in_hsync,
  input  logic        in_vsync,
`ifdef YCC2RGB_MASK_OVERLAY_EN
  input  logic        mask_in,
`endif
  input  logic [7:0]  in_y,
  input  logic [7:0]  in_cb,
  input  logic [7:0]  in_cr,
  output logic        out_valid,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [15:0] out_rgb
);

  // Control delay lines: bit k is the state after stage k+1.
  logic [3:0] vld_q, hs_q, vs_q;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      vld_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      vld_q <= {vld_q[2:0], in_valid};
      hs_q  <= {hs_q[2:0],  in_hsync};
      vs_q  <= {vs_q[2:0],  in_vsync};
    end
  end

  // S1: capture Y, remove chroma offset
  logic [7:0]        y1_q;
  logic signed [8:0] cb1_q, cr1_q, cb_d, cr_d;

  assign cb_d = $signed({1'b0, in_cb}) - 9'sd128;
  assign cr_d = $signed({1'b0, in_cr}) - 9'sd128;

  // S2: chroma products; |454*128| fits comfortably in 18 bits signed
  logic [7:0]         y2_q;
  logic signed [17:0] cb_x, cr_x;
  logic signed [17:0] pr_q, pgb_q, pgr_q, pb_q;
  logic signed [17:0] pr_d, pgb_d, pgr_d, pb_d;

  assign cb_x  = {{9{cb1_q[8]}}, cb1_q};
  assign cr_x  = {{9{cr1_q[8]}}, cr1_q};
  assign pr_d  = cr_x * 18'sd359;
  assign pgb_d = cb_x * 18'sd88;
  assign pgr_d = cr_x * 18'sd183;
  assign pb_d  = cb_x * 18'sd454;

  // S3: 8.8 fixed-point sums, +128 rounds to nearest before the >>8
  logic signed [19:0] ys, pr_x, pgb_x, pgr_x, pb_x;
  logic signed [19:0] r3_q, g3_q, b3_q, r_d, g_d, b_d;

  assign ys    = $signed({4'd0, y2_q, 8'd0});
  assign pr_x  = {{2{pr_q[17]}},  pr_q};
  assign pgb_x = {{2{pgb_q[17]}}, pgb_q};
  assign pgr_x = {{2{pgr_q[17]}}, pgr_q};
  assign pb_x  = {{2{pb_q[17]}},  pb_q};
  assign r_d   = ys + pr_x + 20'sd128;
  assign g_d   = ys - pgb_x - pgr_x + 20'sd128;
  assign b_d   = ys + pb_x + 20'sd128;

  // S4: shift, clamp to 0..255, pack (plain truncation, no dither)
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [19:0] v;
    v = s >>> 8;
    if (v[19])          clamp8 = 8'd0;
    else if (|v[18:8])  clamp8 = 8'hFF;
    else                clamp8 = v[7:0];
  endfunction

  logic [7:0]  r8, g8, b8;
  logic [15:0] rgb_q, rgb_d, conv;
  logic        unused_lsb;

  assign r8   = clamp8(r3_q);
  assign g8   = clamp8(g3_q);
  assign b8   = clamp8(b3_q);
  assign conv = {r8[7:3], g8[7:2], b8[7:3]};
  assign unused_lsb = ^{r8[2:0], g8[1:0], b8[2:0]};

`ifdef YCC2RGB_MASK_OVERLAY_EN
  // Mask rides with the pixel up to S4, where it selects the overlay.
  logic [2:0] mask_q;
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) mask_q <= '0;
    else      mask_q <= {mask_q[1:0], mask_in};
  end
  assign rgb_d = mask_q[2] ? OVERLAY_COLOR : conv;
`else
  logic unused_ovl;
  assign unused_ovl = ^OVERLAY_COLOR;
  assign rgb_d = conv;
`endif

  // Data registers load only when their stage holds a valid pixel.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      y1_q  <= '0; cb1_q <= '0; cr1_q <= '0;
      y2_q  <= '0; pr_q  <= '0; pgb_q <= '0; pgr_q <= '0; pb_q <= '0;
      r3_q  <= '0; g3_q  <= '0; b3_q  <= '0;
      rgb_q <= '0;
    end else begin
      if (in_valid) begin
        y1_q  <= in_y;
        cb1_q <= cb_d;
        cr1_q <= cr_d;
      end
      if (vld_q[0]) begin
        y2_q  <= y1_q;
        pr_q  <= pr_d;
        pgb_q <= pgb_d;
        pgr_q <= pgr_d;
        pb_q  <= pb_d;
      end
      if (vld_q[1]) begin
        r3_q <= r_d;
        g3_q <= g_d;
        b3_q <= b_d;
      end
      if (vld_q[2]) rgb_q <= rgb_d;
    end
  end

  assign out_valid = vld_q[3];
  assign out_hsync = hs_q[3];
  assign out_vsync = vs_q[3];
  assign out_rgb   = rgb_q;

endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Bench for ycbcr_to_rgb565: table of known pixels (incl. clamps and a
// masked pixel 3), single-pulse latency, 640-pixel streaming burst with a
// mid-burst reset. Expected pixels go into a scoreboard queue at drive time
// and are popped when out_valid is seen; syncs/valid are checked every
// cycle against a 4-deep delay line.
module tb_ycbcr_to_rgb565;
  localparam logic [15:0] OVL = 16'hF800;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        in_valid = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, mask_in = 1'b0;
  logic [7:0]  in_y = '0, in_cb = '0, in_cr = '0;
  logic        out_valid, out_hsync, out_vsync;
  logic [15:0] out_rgb;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sbq[$];
  logic [15:0] last_exp = '0;
  logic [3:0]  hv, hh, hs;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  ycbcr_to_rgb565 dut (
    .clk(clk), .Rst(Rst),
    .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync),
`ifdef YCC2RGB_MASK_OVERLAY_EN
    .mask_in(mask_in),
`endif
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .out_valid(out_valid), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_rgb(out_rgb)
  );

  typedef struct {
    logic [7:0]  y, cb, cr;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] model(input int y, input int cb, input int cr, input bit m);
    int r, g, b;
    r = (y * 256 + 359 * (cr - 128) + 128) >>> 8;
    g = (y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128) >>> 8;
    b = (y * 256 + 454 * (cb - 128) + 128) >>> 8;
    if (r < 0) r = 0; if (r > 255) r = 255;
    if (g < 0) g = 0; if (g > 255) g = 255;
    if (b < 0) b = 0; if (b > 255) b = 255;
`ifdef YCC2RGB_MASK_OVERLAY_EN
    if (m) return OVL;
`endif
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic hsy, input logic vsy,
                       input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                       input logic m, input logic [15:0] exp);
    @(posedge clk); #1;
    in_valid = v; in_hsync = hsy; in_vsync = vsy;
    in_y = y; in_cb = cb; in_cr = cr; mask_in = m;
    if (v) sbq.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 16'h0);
  endtask

  // Reference delay line for valid/syncs.
  always @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      hv <= '0; hh <= '0; hs <= '0;
    end else begin
      hv <= {hv[2:0], in_valid};
      hh <= {hh[2:0], in_hsync};
      hs <= {hs[2:0], in_vsync};
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!Rst) last_exp = '0;
      chk("out_valid", 32'(out_valid), 32'(hv[3]));
      chk("out_hsync", 32'(out_hsync), 32'(hh[3]));
      chk("out_vsync", 32'(out_vsync), 32'(hs[3]));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got pixel %h expected none", out_rgb);
        end else begin
          last_exp = sbq.pop_front();
          chk("out_rgb", 32'(out_rgb), 32'(last_exp));
        end
      end else begin
        chk("rgb_hold", 32'(out_rgb), 32'(last_exp));
      end
    end
  end

  initial begin
    vec_t tbl[7];
    int lat;
    logic [7:0] ry, rcb, rcr;
    logic v, hsy, vsy;

    tbl[0] = '{8'd128, 8'd128, 8'd128, 1'b0, 16'h8410};
    tbl[1] = '{8'd255, 8'd128, 8'd128, 1'b0, 16'hFFFF};
    tbl[2] = '{8'd0,   8'd128, 8'd128, 1'b0, 16'h0000};
`ifdef YCC2RGB_MASK_OVERLAY_EN
    tbl[3] = '{8'd255, 8'd128, 8'd255, 1'b1, OVL};
`else
    tbl[3] = '{8'd255, 8'd128, 8'd255, 1'b1, 16'hFD3F};
`endif
    tbl[4] = '{8'd0,   8'd0,   8'd128, 1'b0, 16'h0160};
    tbl[5] = '{8'd255, 8'd255, 8'd128, 1'b0, 16'hFE9F};
    tbl[6] = '{8'd0,   8'd128, 8'd0,   1'b0, 16'h02E0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_hsync", 32'(out_hsync), 32'd0);
    chk("rst_vsync", 32'(out_vsync), 32'd0);
    chk("rst_rgb",   32'(out_rgb),   32'd0);
    mon_en = 1'b1;
    Rst = 1'b1;
    idle(2);

    // Table burst, back-to-back, hsync toggling per pixel
    for (int i = 0; i < 7; i++)
      drive(1'b1, 1'(i % 2), 1'(i == 0), tbl[i].y, tbl[i].cb, tbl[i].cr, tbl[i].m, tbl[i].exp);
    idle(8);
    chk("table_drain", 32'(sbq.size()), 32'd0);

    // Single pulse latency
    drive(1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128, 1'b0, 16'h8410);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin in_valid = 1'b0; in_hsync = 1'b0; end
      if (out_valid && lat == 0) lat = n;
    end
    chk("latency", 32'(lat), 32'd4);

    // 640-pixel burst with gaps, hsync pulses and a mid-burst reset
    for (int i = 0; i < 640; i++) begin
      if (i == 300) begin
        @(posedge clk); #1;
        Rst = 1'b0; in_valid = 1'b0; sbq.delete();
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_hsync", 32'(out_hsync), 32'd0);
        chk("rst_mid_rgb",   32'(out_rgb),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        Rst = 1'b1;
      end
      ry  = 8'($urandom_range(0, 255));
      rcb = 8'($urandom_range(0, 255));
      rcr = 8'($urandom_range(0, 255));
      v   = (i % 97) != 5;
      hsy = (i % 80) < 10;
      vsy = i < 3;
      drive(v, hsy, vsy, ry, rcb, rcr, 1'b0, model(ry, rcb, rcr, 1'b0));
    end
    idle(8);
    chk("burst_drain", 32'(sbq.size()), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
